add_seq_ctrl: RTL
=================

// Module: add_seq_ctrl
// PURPOSE
// - Sequencing stage around the combinational 32-bit sklansky_adder: registers operands, forms a/b/cin, captures y/cout.
// - Supports ADD/SUB/ADC/SBC with a persistent carry flag.
// - Produces NZCV flags and uses valid/ready on both sides. The adder is instantiated beside this block and wired to the add_* ports.
// PARAMETERS
// - WIDTH       32    datapath width; only 32 is legal, matching the adder
// - CARRY_INIT  1'b0  carry flag value after reset or carry_clr
// PORTS
// - clk        in   1   clock, all state on rising edge
// - reset      in   1   synchronous, active-high
// - in_valid   in   1   request valid
// - in_ready   out  1   request accepted when in_valid & in_ready
// - in_op      in   2   00 ADD, 01 SUB, 10 ADC, 11 SBC
// - in_a       in   32  operand A
// - in_b       in   32  operand B
// - carry_clr  in   1   forces carry flag to CARRY_INIT next edge
// - add_a      out  32  to adder a
// - add_b      out  32  to adder b (in_b or ~in_b)
// - add_cin    out  1   to adder cin
// - add_y      in   32  from adder y
// - add_cout   in   1   from adder cout
// - out_valid  out  1   result valid
// - out_ready  in   1   result consumed when out_valid & out_ready
// - out_y      out  32  result
// - out_flags  out  4   {N,Z,C,V}
// - carry_q    out  1   current carry flag
// BEHAVIOUR
// - Two registered stages. S1 holds the operands and drives add_*; S2 holds the result and flags. Accept-to-out_valid latency is 2 cycles.
// - cin and b selection:
//   - ADD: b, cin=0. SUB: ~b, cin=1.
//   - ADC: b, cin=carry_q. SBC: ~b, cin=carry_q.
// - Handshake:
//   - s1_adv = s1_valid & (!s2_valid | out_ready).
//   - in_ready = !s1_valid | s1_adv. No combinational in_valid->in_ready path.
//   - Full throughput: one op per cycle when out_ready is held high.
// - Back-pressure: when out_valid & !out_ready, S2 holds and S1 holds. out_y and out_flags remain stable until the transfer.
// - Flags are captured into S2 on s1_adv:
//   - N = y[31]; Z = (y == 0); C = add_cout (SUB/SBC: C=1 means no borrow).
//   - V = (add_a[31] == add_b[31]) & (y[31] != add_a[31]).
// - Carry flag:
//   - carry_q <= add_cout on s1_adv.
//   - An ADC/SBC in S1 therefore sees the carry of every older op, with no bubble.
//   - If carry_clr and s1_adv occur together, carry_clr wins.
// - Reset:
//   - s1_valid=0, s2_valid=0, out_valid=0, out_y=0, out_flags=0, carry_q=CARRY_INIT.
//   - add_a=0, add_b=0, add_cin=0 while S1 is empty; in_ready=0 during reset.
//   - Reset mid-operation drops all in-flight ops with no output.
// - Wrap-around: the sum is modulo 2^32 and cout is reported, never lost.
// CONFIGURATION
// - ADD_SEQ_SAT_EN defined:
//   - Adds port in_sat (in, 1), captured with the op.
//   - If in_sat and V, out_y saturates to 32'h7FFFFFFF (y[31]=1) or 32'h80000000 (y[31]=0). N and Z are recomputed from the saturated value.
//   - V and C report the raw adder values.
// - ADD_SEQ_SAT_EN undefined: no in_sat port; the result always wraps.
// TESTING
// - ADD 0xFFFFFFFF+0x1, out_ready=1 -> cycle 2: out_y=0x0, flags N0 Z1 C1 V0, carry_q=1.
// - SUB 5-7 -> out_y=0xFFFFFFFE, N1 Z0 C0 V0. SUB 7-5 -> out_y=2, C1.
// - Back-to-back ADD 0xFFFFFFFF+1 then ADC 0+0 -> second out_y=1. Repeat with carry_clr pulsed between -> out_y=0.
// - ADD 0x7FFFFFFF+1 -> out_y=0x80000000, V1. With SAT_EN and in_sat=1 -> out_y=0x7FFFFFFF, N0, V1.
// - out_ready=0 for 5 cycles with 3 ops offered -> 2 accepted, in_ready=0, out_y stable. Release -> ops emerge in order, no loss.
// - reset asserted with both stages valid -> next cycle out_valid=0, carry_q=CARRY_INIT. The first op after reset behaves per test 1.

Source files
------------

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: two-stage sequencer around an external 32-bit adder.
// Handles ADD/SUB/ADC/SBC with a persistent carry flag and NZCV flags,
// with valid/ready handshakes on both sides.
// Optional build macro: ADD_SEQ_SAT_EN (adds in_sat, signed saturation on overflow).
module add_seq_ctrl #(
  parameter int unsigned WIDTH      = 32,   // only 32 is legal, matching the adder
  parameter logic        CARRY_INIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
`ifdef ADD_SEQ_SAT_EN
  input  logic             in_sat,
`endif
  input  logic             carry_clr,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_y,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [3:0]       out_flags,
  output logic             carry_q
);

  localparam int unsigned MSB = WIDTH - 1;

  // op[0] selects ~b, op[1] selects carry-in from the carry flag
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBC = 2'b11
  } op_e;

  logic             r_s1_valid;
  op_e              r_s1_op;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
`ifdef ADD_SEQ_SAT_EN
  logic             r_s1_sat;
`endif
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_y;
  logic [3:0]       r_s2_flags;
  logic             r_carry;

  logic             w_s1_adv;
  logic             w_accept;
  logic             w_v;
  logic [WIDTH-1:0] w_res;

  assign w_s1_adv = r_s1_valid & (~r_s2_valid | out_ready);
  assign in_ready = ~reset & (~r_s1_valid | w_s1_adv);
  assign w_accept = in_valid & in_ready;

  // Adder operand/carry-in formation; all zero while S1 is empty
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (r_s1_valid) begin
      add_a = r_s1_a;
      add_b = r_s1_op[0] ? ~r_s1_b : r_s1_b;
      unique case (r_s1_op)
        OP_ADD:  add_cin = 1'b0;
        OP_SUB:  add_cin = 1'b1;
        OP_ADC:  add_cin = r_carry;
        OP_SBC:  add_cin = r_carry;
        default: add_cin = 1'b0;
      endcase
    end
  end

  assign w_v = (add_a[MSB] == add_b[MSB]) & (add_y[MSB] != add_a[MSB]);

  // Final result: raw sum, or clamped to the signed limit on requested overflow
  always_comb begin
    w_res = add_y;
`ifdef ADD_SEQ_SAT_EN
    if (r_s1_sat && w_v) begin
      w_res = add_y[MSB] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
    end
`endif
  end

  // Stage 1: operand capture on accept, drains when the op moves to S2
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= OP_ADD;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
`ifdef ADD_SEQ_SAT_EN
      r_s1_sat   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_op    <= op_e'(in_op);
      r_s1_a     <= in_a;
      r_s1_b     <= in_b;
`ifdef ADD_SEQ_SAT_EN
      r_s1_sat   <= in_sat;
`endif
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage 2: result and flags, held stable while the consumer stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_s2_y     <= '0;
      r_s2_flags <= 4'b0000;
    end else if (w_s1_adv) begin
      r_s2_valid <= 1'b1;
      r_s2_y     <= w_res;
      r_s2_flags <= {w_res[MSB], (w_res == '0), add_cout, w_v};
    end else if (out_ready) begin
      r_s2_valid <= 1'b0;
    end
  end

  // Carry flag: follows each retiring op; clear takes priority
  always_ff @(posedge clk) begin
    if (reset || carry_clr) begin
      r_carry <= CARRY_INIT;
    end else if (w_s1_adv) begin
      r_carry <= add_cout;
    end
  end

  assign out_valid = r_s2_valid;
  assign out_y     = r_s2_y;
  assign out_flags = r_s2_flags;
  assign carry_q   = r_carry;

endmodule
